sdr_memtest: RTL and testbench

- Parametrised SDRAM pattern tester; the next generation of the board bring-up SDRAM test, which used one fixed pattern and LED status only.
- Sits between board top-level and the SDRAM controller's command/data interface.
- After controller init, writes a selectable pattern over a configurable region in bursts, reads it back and compares.
- Reports pass count, saturating error count and first-failure capture; optionally loops forever, inverting data on odd passes.

---
 rtl/sdr_memtest.sv | 159 +++++++++++++++
 tb/tb_sdr_memtest.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sdr_memtest.sv
// SDRAM pattern tester: writes a mode-selected pattern over a region in bursts, reads it back, compares.
// Commands wait on cmd_ack, write beats advance on wr_ready, read beats on rd_valid; one burst in flight.
module sdr_memtest #(
   parameter int ADDR_WIDTH    = 22,
   parameter int DATA_WIDTH    = 16,
   parameter int BURST_LEN     = 8,
   parameter int REGION_LOG2   = 22,
   parameter int LOOP          = 1,
   parameter int HALT_ON_ERROR = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  init_done,
   input  logic                  start,
   input  logic [1:0]            mode,
   output logic                  cmd_req,
   input  logic                  cmd_ack,
   output logic                  cmd_we,
   output logic [ADDR_WIDTH-1:0] cmd_addr,
   output logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  wr_ready,
   input  logic                  rd_valid,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic                  busy,
   output logic                  done,
   output logic                  fail,
   output logic [15:0]           pass_count,
   output logic [15:0]           err_count,
   output logic [ADDR_WIDTH-1:0] err_addr,
   output logic [DATA_WIDTH-1:0] err_expect,
   output logic [DATA_WIDTH-1:0] err_got
);
   localparam int EW = REGION_LOG2 + DATA_WIDTH;
   localparam logic [REGION_LOG2-1:0] BEAT_MASK = REGION_LOG2'(BURST_LEN - 1);

   typedef enum logic [2:0] {IDLE, WAIT_INIT, WR_CMD, WR_DATA, RD_CMD, RD_DATA, STOP} state_t;

   state_t                  state;
   logic [1:0]              mode_q;
   logic                    phase;
   logic [REGION_LOG2-1:0]  addr;
   logic                    last_beat;
   logic                    last_burst;
   logic                    mismatch;
   logic [DATA_WIDTH-1:0]   expect_dat;

   function automatic logic [DATA_WIDTH-1:0] pattern(input logic [REGION_LOG2-1:0] a,
                                                     input logic [1:0] m, input logic p);
      logic [EW-1:0]         ax;
      logic [DATA_WIDTH-1:0] b;
      ax = EW'(a);
      b  = '0;
      case (m)
         2'd0:    b = ax[DATA_WIDTH-1:0];
         2'd1:    b = DATA_WIDTH'(1) << (ax % EW'(DATA_WIDTH));
         2'd2:    b = ~ax[DATA_WIDTH-1:0];
         default: for (int i = 0; i < DATA_WIDTH; i++) b[i] = ((i % 2) == 0) ^ a[0];
      endcase
      return b ^ {DATA_WIDTH{p}};
   endfunction

   // addr walks word by word; it is burst-aligned whenever a command is pending
   assign expect_dat = pattern(addr, mode_q, phase);
   assign last_beat  = (addr & BEAT_MASK) == BEAT_MASK;
   assign last_burst = &addr;
   assign mismatch   = rd_data != expect_dat;
   assign cmd_addr   = ADDR_WIDTH'(addr);
   assign wr_data    = (state == WR_DATA) ? expect_dat : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         mode_q     <= 2'd0;
         phase      <= 1'b0;
         addr       <= '0;
         cmd_req    <= 1'b0;
         cmd_we     <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         fail       <= 1'b0;
         pass_count <= '0;
         err_count  <= '0;
         err_addr   <= '0;
         err_expect <= '0;
         err_got    <= '0;
      end else begin
         case (state)
            IDLE, STOP: if (start) begin
               mode_q     <= mode;
               phase      <= 1'b0;
               addr       <= '0;
               pass_count <= '0;
               err_count  <= '0;
               fail       <= 1'b0;
               err_addr   <= '0;
               err_expect <= '0;
               err_got    <= '0;
               busy       <= 1'b1;
               done       <= 1'b0;
               state      <= WAIT_INIT;
            end
            WAIT_INIT: if (init_done) begin
               cmd_req <= 1'b1;
               cmd_we  <= 1'b1;
               state   <= WR_CMD;
            end
            WR_CMD, RD_CMD: if (cmd_ack) begin
               cmd_req <= 1'b0;
               state   <= (state == WR_CMD) ? WR_DATA : RD_DATA;
            end
            WR_DATA: if (wr_ready) begin
               addr <= addr + 1'b1;
               if (last_beat) begin
                  cmd_req <= 1'b1;
                  cmd_we  <= !last_burst;
                  state   <= last_burst ? RD_CMD : WR_CMD;
               end
            end
            RD_DATA: if (rd_valid) begin
               addr <= addr + 1'b1;
               if (mismatch) begin
                  fail <= 1'b1;
                  if (err_count != 16'hFFFF) err_count <= err_count + 1'b1;
                  if (!fail) begin
                     err_addr   <= ADDR_WIDTH'(addr);
                     err_expect <= expect_dat;
                     err_got    <= rd_data;
                  end
               end
               if (last_beat) begin
                  // the beat just compared counts towards the halt decision
                  if ((HALT_ON_ERROR != 0) && (fail || mismatch)) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= STOP;
                  end else if (!last_burst) begin
                     cmd_req <= 1'b1;
                     cmd_we  <= 1'b0;
                     state   <= RD_CMD;
                  end else begin
                     pass_count <= pass_count + 1'b1;
                     phase      <= ~phase;
                     if (LOOP != 0) begin
                        cmd_req <= 1'b1;
                        cmd_we  <= 1'b1;
                        state   <= WR_CMD;
                     end else begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= STOP;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sdr_memtest.sv
// Bench for sdr_memtest: two instances (one-pass/halting, looping) driven by a randomly stalling memory model.
module tb_sdr_memtest;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]  rst_v, init_v, start_v, ack_v, wrdy_v, rvld_v;
   logic [1:0]  req_v, we_v, busy_v, done_v, fail_v;
   logic [1:0]  mode_v [2];
   logic [15:0] rdat_v [2];
   logic [5:0]  addr_v [2];
   logic [5:0]  ea_v   [2];
   logic [15:0] wdat_v [2];
   logic [15:0] pc_v   [2];
   logic [15:0] ec_v   [2];
   logic [15:0] ee_v   [2];
   logic [15:0] eg_v   [2];

   sdr_memtest #(.ADDR_WIDTH(6), .DATA_WIDTH(16), .BURST_LEN(4), .REGION_LOG2(4),
                 .LOOP(0), .HALT_ON_ERROR(1)) dut_a (
      .clk(clk), .reset(rst_v[0]), .init_done(init_v[0]), .start(start_v[0]), .mode(mode_v[0]),
      .cmd_req(req_v[0]), .cmd_ack(ack_v[0]), .cmd_we(we_v[0]), .cmd_addr(addr_v[0]),
      .wr_data(wdat_v[0]), .wr_ready(wrdy_v[0]), .rd_valid(rvld_v[0]), .rd_data(rdat_v[0]),
      .busy(busy_v[0]), .done(done_v[0]), .fail(fail_v[0]), .pass_count(pc_v[0]),
      .err_count(ec_v[0]), .err_addr(ea_v[0]), .err_expect(ee_v[0]), .err_got(eg_v[0]));

   sdr_memtest #(.ADDR_WIDTH(6), .DATA_WIDTH(16), .BURST_LEN(4), .REGION_LOG2(5),
                 .LOOP(1), .HALT_ON_ERROR(0)) dut_b (
      .clk(clk), .reset(rst_v[1]), .init_done(init_v[1]), .start(start_v[1]), .mode(mode_v[1]),
      .cmd_req(req_v[1]), .cmd_ack(ack_v[1]), .cmd_we(we_v[1]), .cmd_addr(addr_v[1]),
      .wr_data(wdat_v[1]), .wr_ready(wrdy_v[1]), .rd_valid(rvld_v[1]), .rd_data(rdat_v[1]),
      .busy(busy_v[1]), .done(done_v[1]), .fail(fail_v[1]), .pass_count(pc_v[1]),
      .err_count(ec_v[1]), .err_addr(ea_v[1]), .err_expect(ee_v[1]), .err_got(eg_v[1]));

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, got, exp);
      end
   endtask

   // Reference pattern straight from the pattern rules
   function automatic logic [15:0] ref_pat(input int a, input int m, input int p);
      logic [15:0] b;
      logic [31:0] av;
      av = 32'(a);
      case (m)
         0:       b = av[15:0];
         1:       b = 16'h1 << (a % 16);
         2:       b = ~av[15:0];
         default: b = ((a % 2) == 0) ? 16'h5555 : 16'hAAAA;
      endcase
      if ((p % 2) == 1) b = ~b;
      return b;
   endfunction

   // Memory model state, one slot per DUT
   int          region [2] = '{16, 32};
   int          ph [2], base [2], beat [2], st_c [2], st_w [2], st_r [2];
   int          ncmd [2], pass_m [2], rd_cmds [2], mode_m [2], fault_m [2];
   int          probe_a [2], probe_p [2];
   logic [15:0] probe_v [2];
   logic [15:0] mem [2][32];

   task automatic model_step(input int d);
      int          a;
      int          nb;
      logic [15:0] v;
      nb = region[d] / 4;
      ack_v[d]  = 1'b0;
      wrdy_v[d] = 1'b0;
      rvld_v[d] = 1'b0;
      rdat_v[d] = 16'($urandom);
      if (rst_v[d]) begin
         ph[d] = 0; st_c[d] = 0; st_w[d] = 0; st_r[d] = 0;
         return;
      end
      case (ph[d])
         0: begin
            wrdy_v[d] = 1'($urandom_range(0, 1));
            rvld_v[d] = 1'($urandom_range(0, 1));
            if (req_v[d]) begin
               if (st_c[d] > 0) st_c[d]--;
               else begin
                  ack_v[d] = 1'b1;
                  st_c[d]  = int'($urandom_range(0, 3));
                  check("cmd_we", 32'(we_v[d]), 32'((ncmd[d] % (2 * nb)) < nb));
                  check("cmd_addr", 32'(addr_v[d]), 32'((ncmd[d] % nb) * 4));
                  ph[d]   = we_v[d] ? 1 : 2;
                  base[d] = int'(addr_v[d]);
                  beat[d] = 0;
                  if (!we_v[d]) rd_cmds[d]++;
                  ncmd[d]++;
               end
            end
         end
         1: begin
            rvld_v[d] = 1'($urandom_range(0, 1));
            if (st_w[d] > 0) st_w[d]--;
            else begin
               wrdy_v[d] = 1'b1;
               st_w[d]   = int'($urandom_range(0, 3));
               a = (base[d] + beat[d]) % region[d];
               mem[d][a] = wdat_v[d];
               check("wr_data", 32'(wdat_v[d]), 32'(ref_pat(a, mode_m[d], pass_m[d])));
               if (a == probe_a[d] && pass_m[d] == probe_p[d]) probe_v[d] = wdat_v[d];
               beat[d]++;
               if (beat[d] == 4) ph[d] = 0;
            end
         end
         default: begin
            wrdy_v[d] = 1'($urandom_range(0, 1));
            if (st_r[d] > 0) st_r[d]--;
            else begin
               rvld_v[d] = 1'b1;
               st_r[d]   = int'($urandom_range(0, 3));
               a = (base[d] + beat[d]) % region[d];
               v = mem[d][a];
               if (fault_m[d] == 1 && a == 9) v[0] = 1'b0;
               else if (fault_m[d] == 2) v = 16'hAAAA;
               rdat_v[d] = v;
               beat[d]++;
               if (beat[d] == 4) begin
                  ph[d] = 0;
                  if (a == region[d] - 1) pass_m[d]++;
               end
            end
         end
      endcase
   endtask

   initial forever begin
      @(negedge clk);
      model_step(0);
      model_step(1);
   end

   typedef struct {
      int d; int mode; int fault; int do_rst; int target;
      int probe_a; int probe_p; logic [15:0] probe_val;
      int exp_done; int exp_fail; int exp_pc; int exp_ec; int exp_ea;
      logic [15:0] exp_ee; logic [15:0] exp_eg; int exp_rdc;
   } vec_t;

   vec_t tbl [6];

   initial begin
      bit ok;
      int d;
      tbl[0] = '{0, 0, 0, 0, 1,  9, 0, 16'h0009, 1, 0, 1, 0, 0, 16'h0000, 16'h0000, 4};
      tbl[1] = '{0, 0, 1, 0, 1,  9, 0, 16'h0009, 1, 1, 0, 1, 9, 16'h0009, 16'h0008, 3};
      tbl[2] = '{0, 3, 2, 0, 1,  1, 0, 16'hAAAA, 1, 1, 0, 2, 0, 16'h5555, 16'hAAAA, 1};
      tbl[3] = '{1, 2, 0, 1, 3,  3, 1, 16'h0003, 0, 0, 3, 0, 0, 16'h0000, 16'h0000, 24};
      tbl[4] = '{1, 1, 0, 1, 1, 17, 0, 16'h0002, 0, 0, 1, 0, 0, 16'h0000, 16'h0000, 8};
      tbl[5] = '{1, 0, 1, 1, 2,  9, 1, 16'hFFF6, 0, 1, 2, 1, 9, 16'h0009, 16'h0008, 16};

      rst_v = 2'b11; init_v = 2'b00; start_v = 2'b00;
      ack_v = 2'b00; wrdy_v = 2'b00; rvld_v = 2'b00;
      mode_v[0] = 2'd0; mode_v[1] = 2'd0; rdat_v[0] = '0; rdat_v[1] = '0;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         check("rst_cmd_req",  32'(req_v[k]),  0);
         check("rst_cmd_we",   32'(we_v[k]),   0);
         check("rst_cmd_addr", 32'(addr_v[k]), 0);
         check("rst_wr_data",  32'(wdat_v[k]), 0);
         check("rst_busy",     32'(busy_v[k]), 0);
         check("rst_done",     32'(done_v[k]), 0);
         check("rst_fail",     32'(fail_v[k]), 0);
         check("rst_pass",     32'(pc_v[k]),   0);
         check("rst_errcnt",   32'(ec_v[k]),   0);
         check("rst_erraddr",  32'(ea_v[k]),   0);
         check("rst_errexp",   32'(ee_v[k]),   0);
         check("rst_errgot",   32'(eg_v[k]),   0);
      end
      rst_v = 2'b00;

      // Reset landing in the middle of a write burst
      mode_m[0] = 2; fault_m[0] = 0; probe_a[0] = -1; ncmd[0] = 0; pass_m[0] = 0; rd_cmds[0] = 0;
      init_v[0] = 1'b1; mode_v[0] = 2'd2; start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      ok = 1'b0;
      for (int c = 0; c < 200 && !ok; c++) begin
         @(negedge clk);
         ok = (ph[0] == 1 && beat[0] == 1);
      end
      check("reach_wr_data", 32'(ok), 1);
      rst_v[0] = 1'b1;
      @(negedge clk);
      check("midrst_cmd_req", 32'(req_v[0]),  0);
      check("midrst_busy",    32'(busy_v[0]), 0);
      check("midrst_wr_data", 32'(wdat_v[0]), 0);
      check("midrst_pass",    32'(pc_v[0]),   0);
      check("midrst_errcnt",  32'(ec_v[0]),   0);
      @(negedge clk);
      rst_v[0] = 1'b0; init_v[0] = 1'b0;

      for (int i = 0; i < 6; i++) begin
         d = tbl[i].d;
         if (tbl[i].do_rst != 0) begin
            rst_v[d] = 1'b1;
            @(negedge clk);
            @(negedge clk);
            rst_v[d] = 1'b0;
         end
         mode_m[d] = tbl[i].mode; fault_m[d] = tbl[i].fault;
         probe_a[d] = tbl[i].probe_a; probe_p[d] = tbl[i].probe_p; probe_v[d] = 16'hDEAD;
         ncmd[d] = 0; pass_m[d] = 0; rd_cmds[d] = 0;
         init_v[d] = 1'b0; mode_v[d] = 2'(tbl[i].mode); start_v[d] = 1'b1;
         @(negedge clk);
         start_v[d] = 1'b0;
         repeat (3) @(negedge clk);
         check("wait_init_req",  32'(req_v[d]),  0);
         check("wait_init_busy", 32'(busy_v[d]), 1);
         init_v[d] = 1'b1;
         repeat (3) @(negedge clk);
         // a start while busy must not relatch the mode; init_done dropping is ignored too
         mode_v[d] = 2'((tbl[i].mode + 1) % 4); start_v[d] = 1'b1;
         @(negedge clk);
         start_v[d] = 1'b0; init_v[d] = 1'b0;
         ok = (d == 0) ? bit'(done_v[0]) : (int'(pc_v[1]) == tbl[i].target);
         for (int c = 0; c < 5000 && !ok; c++) begin
            @(negedge clk);
            ok = (d == 0) ? bit'(done_v[0]) : (int'(pc_v[1]) == tbl[i].target);
         end
         check($sformatf("v%0d_complete", i), 32'(ok),          1);
         check($sformatf("v%0d_done", i),     32'(done_v[d]),   32'(tbl[i].exp_done));
         check($sformatf("v%0d_busy", i),     32'(busy_v[d]),   32'(1 - tbl[i].exp_done));
         check($sformatf("v%0d_fail", i),     32'(fail_v[d]),   32'(tbl[i].exp_fail));
         check($sformatf("v%0d_pass", i),     32'(pc_v[d]),     32'(tbl[i].exp_pc));
         check($sformatf("v%0d_errcnt", i),   32'(ec_v[d]),     32'(tbl[i].exp_ec));
         check($sformatf("v%0d_erraddr", i),  32'(ea_v[d]),     32'(tbl[i].exp_ea));
         check($sformatf("v%0d_errexp", i),   32'(ee_v[d]),     32'(tbl[i].exp_ee));
         check($sformatf("v%0d_errgot", i),   32'(eg_v[d]),     32'(tbl[i].exp_eg));
         check($sformatf("v%0d_rdcmds", i),   32'(rd_cmds[d]),  32'(tbl[i].exp_rdc));
         check($sformatf("v%0d_probe", i),    32'(probe_v[d]),  32'(tbl[i].probe_val));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
